// File: rtl/addsub_pipe_if.sv
// ============================================================================
// Module      : addsub_pipe_if
// Description : Streaming operand/result bundle for addsub_pipe.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;

    // master is the producer/consumer environment, slave is the datapath block
    modport master (
        output in_valid, dataa, datab, op, out_ready,
        input  in_ready, out_valid, result, carry, overflow
    );

    modport slave (
        input  in_valid, dataa, datab, op, out_ready,
        output in_ready, out_valid, result, carry, overflow
    );
endinterface

`default_nettype wire

// File: rtl/addsub_pipe.sv
// ============================================================================
// Module      : addsub_pipe
// Description : Pipelined add/sub/accumulate with valid/ready handshake and
//               carry/overflow flags. Define ADDSUB_SAT_EN for signed saturation.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    addsub_pipe_if.slave    bus
);
    localparam logic [1:0] c_OP_SUB  = 2'b00;
    localparam logic [1:0] c_OP_ADD  = 2'b01;
    localparam logic [1:0] c_OP_ACC  = 2'b10;
    localparam logic [1:0] c_OP_LOAD = 2'b11;
    localparam int         c_MSB     = WIDTH - 1;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic               advance;
    logic               accept;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     ext;
    logic [WIDTH-1:0]   calc_res;
    logic               calc_carry;
    logic               calc_ovf;

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] car_q;
    logic [LATENCY-1:0] ovf_q;
    logic [WIDTH-1:0]   res_q [LATENCY];

    // A single enable moves the whole pipe; only the output stage can stall it.
    assign advance      = bus.out_ready | ~vld_q[LATENCY-1];
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    always_comb begin
        opb      = bus.op[1] ? acc_q : bus.datab;
        ext      = '0;
        calc_ovf = 1'b0;
        case (bus.op)
            c_OP_SUB: begin
                ext      = {1'b0, bus.dataa} - {1'b0, opb};
                calc_ovf = (bus.dataa[c_MSB] ^ opb[c_MSB]) & (ext[c_MSB] ^ bus.dataa[c_MSB]);
            end
            c_OP_ADD, c_OP_ACC: begin
                ext      = {1'b0, bus.dataa} + {1'b0, opb};
                calc_ovf = ~(bus.dataa[c_MSB] ^ opb[c_MSB]) & (ext[c_MSB] ^ bus.dataa[c_MSB]);
            end
            c_OP_LOAD: begin
                ext      = {1'b0, bus.dataa};
                calc_ovf = 1'b0;
            end
            default: begin
                ext      = '0;
                calc_ovf = 1'b0;
            end
        endcase
        // For SUB the top bit of the extended difference is the borrow (a < b).
        calc_carry = ext[WIDTH];
        calc_res   = ext[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
        if (calc_ovf) begin
            calc_res = bus.dataa[c_MSB] ? c_SAT_NEG : c_SAT_POS;
        end
`endif
    end

    always_comb begin
        acc_d = acc_q;
        if (accept && bus.op[1]) begin
            acc_d = calc_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q[0] <= 1'b0;
            res_q[0] <= '0;
            car_q[0] <= 1'b0;
            ovf_q[0] <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= accept;
            if (accept) begin
                res_q[0] <= calc_res;
                car_q[0] <= calc_carry;
                ovf_q[0] <= calc_ovf;
            end
        end
    end

    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q[k] <= 1'b0;
                res_q[k] <= '0;
                car_q[k] <= 1'b0;
                ovf_q[k] <= 1'b0;
            end else if (advance) begin
                vld_q[k] <= vld_q[k-1];
                res_q[k] <= res_q[k-1];
                car_q[k] <= car_q[k-1];
                ovf_q[k] <= ovf_q[k-1];
            end
        end
    end

    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.result    = res_q[LATENCY-1];
    assign bus.carry     = car_q[LATENCY-1];
    assign bus.overflow  = ovf_q[LATENCY-1];

    a_hold_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.result) && $stable(bus.carry) && $stable(bus.overflow))
    );

endmodule

`default_nettype wire

// File: tb/tb_addsub_pipe.sv
// ============================================================================
// Module      : tb_addsub_pipe
// Description : Scoreboard bench for addsub_pipe (WIDTH=8; LATENCY 2, 1 and 4).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_addsub_pipe;
    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       o;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(8)) bus ();
    addsub_pipe_if #(.WIDTH(8)) a1  ();
    addsub_pipe_if #(.WIDTH(8)) a4  ();

    addsub_pipe #(.WIDTH(8), .LATENCY(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    addsub_pipe #(.WIDTH(8), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a1.slave));
    addsub_pipe #(.WIDTH(8), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(a4.slave));

    exp_t       sb_q [$];
    logic [7:0] m_acc;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       last_acc;
    logic       prev_stall;
    logic [7:0] prev_res;
    logic       prev_c, prev_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [7:0] acc);
        logic [8:0] e;
        logic [7:0] y;
        exp_t       x;
        y = (op == 2'b10) ? acc : b;
        case (op)
            2'b00:   e = {1'b0, a} - {1'b0, y};
            2'b11:   e = {1'b0, a};
            default: e = {1'b0, a} + {1'b0, y};
        endcase
        x.r = e[7:0];
        x.c = e[8];
        if (op == 2'b00)      x.o = (a[7] != y[7]) && (e[7] != a[7]);
        else if (op == 2'b11) x.o = 1'b0;
        else                  x.o = (a[7] == y[7]) && (e[7] != a[7]);
`ifdef ADDSUB_SAT_EN
        if (x.o) x.r = a[7] ? 8'h80 : 8'h7F;
`endif
        return x;
    endfunction

    // One clock: sample mid low phase, update scoreboard, then cross the edge.
    task automatic cycle();
        exp_t e;
        #2;
        if (rst_n) begin
            if (bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
            if (!bus.out_valid)                  check("in_ready_empty", bus.in_ready, 1);
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_result", bus.result, prev_res);
                check("hold_flags", {bus.carry, bus.overflow}, {prev_c, prev_o});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", bus.result, e.r);
                    check("carry", bus.carry, e.c);
                    check("overflow", bus.overflow, e.o);
                end
            end
            last_acc = bus.in_valid && bus.in_ready;
            if (last_acc) begin
                e = model(bus.op, bus.dataa, bus.datab, m_acc);
                if (bus.op[1]) m_acc = e.r;
                sb_q.push_back(e);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            prev_c     = bus.carry;
            prev_o     = bus.overflow;
        end else begin
            sb_q.delete();
            m_acc      = 8'h00;
            last_acc   = 1'b0;
            prev_stall = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dataa    = a;
        bus.datab    = b;
    endtask

    task automatic drain(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
        check(tag, sb_q.size(), 0);
    endtask

    logic [1:0] t_op [6];
    logic [7:0] t_a  [6];
    logic [7:0] t_b  [6];

    initial begin
        bus.in_valid = 0; bus.op = 0; bus.dataa = 0; bus.datab = 0; bus.out_ready = 1;
        a1.in_valid  = 0; a1.op  = 0; a1.dataa  = 0; a1.datab  = 0; a1.out_ready  = 1;
        a4.in_valid  = 0; a4.op  = 0; a4.dataa  = 0; a4.datab  = 0; a4.out_ready  = 1;
        m_acc = 0; last_acc = 0; prev_stall = 0; prev_res = 0; prev_c = 0; prev_o = 0;
        @(negedge clk);

        // Reset state
        cycle(); cycle();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.carry, bus.overflow}, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // First ACC after reset starts from a cleared accumulator
        drive(2'b10, 8'd5, 8'd0); cycle();
        bus.in_valid = 0; cycle();
        check("acc_first_valid", bus.out_valid, 1);
        check("acc_first_res", bus.result, 8'd5);
        cycle();

        // ADD with carry, latency of two edges
        drive(2'b01, 8'hF0, 8'h20); cycle();
        check("add_lat_early", bus.out_valid, 0);
        bus.in_valid = 0; cycle();
        check("add_lat_valid", bus.out_valid, 1);
        check("add_res", bus.result, 8'h10);
        check("add_flags", {bus.carry, bus.overflow}, 2'b10);
        cycle();

        // SUB with borrow
        drive(2'b00, 8'h10, 8'h20); cycle();
        bus.in_valid = 0; cycle();
        check("sub_res", bus.result, 8'hF0);
        check("sub_borrow", bus.carry, 1);
        cycle();

        // Signed overflow
        drive(2'b01, 8'h70, 8'h20); cycle();
        bus.in_valid = 0; cycle();
`ifdef ADDSUB_SAT_EN
        check("ovf_res", bus.result, 8'h7F);
`else
        check("ovf_res", bus.result, 8'h90);
`endif
        check("ovf_flag", bus.overflow, 1);
        cycle();

        // Accumulator chain with an interleaved ADD
        t_op[0] = 2'b11; t_a[0] = 8'd3; t_b[0] = 8'd0;
        t_op[1] = 2'b10; t_a[1] = 8'd4; t_b[1] = 8'd99;
        t_op[2] = 2'b10; t_a[2] = 8'd5; t_b[2] = 8'd0;
        t_op[3] = 2'b01; t_a[3] = 8'd1; t_b[3] = 8'd1;
        t_op[4] = 2'b10; t_a[4] = 8'd0; t_b[4] = 8'd0;
        for (int i = 0; i < 5; i++) begin
            drive(t_op[i], t_a[i], t_b[i]);
            cycle();
            if (i >= 1) check("chain_no_bubble", bus.out_valid, 1);
        end
        drain("chain_drain");

        // Backpressure mid-stream
        for (int i = 0; i < 6; i++) begin
            t_op[i] = 2'($urandom_range(0, 3));
            t_a[i]  = 8'($urandom_range(0, 255));
            t_b[i]  = 8'($urandom_range(0, 255));
        end
        begin
            int k = 0;
            for (int t = 0; t < 40 && (k < 6 || sb_q.size() != 0); t++) begin
                if (k < 6) drive(t_op[k], t_a[k], t_b[k]);
                else       bus.in_valid = 1'b0;
                bus.out_ready = !(t >= 3 && t < 6);
                cycle();
                if (last_acc) k++;
            end
            check("bp_all_sent", k, 6);
        end
        drain("bp_drain");

        // Random traffic with random stalls
        for (int i = 0; i < 60; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op        = 2'($urandom_range(0, 3));
            bus.dataa     = 8'($urandom_range(0, 255));
            bus.datab     = 8'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand_drain");

        // Reset with two ops in flight
        bus.out_ready = 0;
        drive(2'b11, 8'h55, 8'h00); cycle();
        drive(2'b01, 8'h01, 8'h02); cycle();
        check("inflight_valid", bus.out_valid, 1);
        bus.in_valid = 0; bus.out_ready = 1; rst_n = 0;
        cycle();
        check("rst_flush_valid", bus.out_valid, 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rst_no_output", bus.out_valid, 0);
        end
        drive(2'b10, 8'd1, 8'd0); cycle();
        bus.in_valid = 0; cycle();
        check("acc_after_rst", bus.result, 8'd1);
        drain("rst_drain");

        // LATENCY 1 and 4 variants of the ADD/SUB directed cases
        for (int j = 0; j < 2; j++) begin
            a1.in_valid = 1; a4.in_valid = 1;
            a1.op    = (j == 0) ? 2'b01 : 2'b00;  a4.op    = a1.op;
            a1.dataa = (j == 0) ? 8'hF0 : 8'h10;  a4.dataa = a1.dataa;
            a1.datab = 8'h20;                     a4.datab = 8'h20;
            cycle();
            a1.in_valid = 0; a4.in_valid = 0;
            for (int n = 1; n <= 5; n++) begin
                check("l1_valid", a1.out_valid, (n == 1));
                check("l4_valid", a4.out_valid, (n == 4));
                if (n == 1) begin
                    check("l1_res", a1.result, (j == 0) ? 8'h10 : 8'hF0);
                    check("l1_carry", a1.carry, 1);
                end
                if (n == 4) begin
                    check("l4_res", a4.result, (j == 0) ? 8'h10 : 8'hF0);
                    check("l4_carry", a4.carry, 1);
                end
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
